// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
// The 11-bit frame layout is fixed: start, 7 data bits, d9, d10, stop.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int BAUD_W_DEF = 19;

  localparam logic [FRAME_BITS-1:0] IDLE_SR   = '1;
  localparam logic                  START_BIT = 1'b0;
  localparam logic                  STOP_BIT  = 1'b1;

  // TX_LOAD is the load_d cycle; TX_SHIFT is the doit phase.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOAD  = 2'd1,
    TX_SHIFT = 2'd2
  } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_engine_decode.sv
// Parity / bit-9 / bit-10 decode for the transmit frame.
// Produces the two bits that follow the seven low data bits on the line.
module uart_tx_engine_decode (
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic [7:0] d,
  output logic       d9,
  output logic       d10
);

  logic par7;
  logic par8;

  // Even parity makes the total count of ones even; odd inverts that bit.
  assign par7 = (^d[6:0]) ^ ohel;
  assign par8 = (^d)      ^ ohel;

  assign d9  = eight ? d[7] : (pen ? par7 : 1'b1);
  assign d10 = (eight && pen) ? par8 : 1'b1;

endmodule : uart_tx_engine_decode

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: latches a byte on load, builds an 11-bit frame
// and shifts it out LSB-first on tx, one bit every k clocks.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_W = BAUD_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [7:0]        data,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] k,
  output logic              tx,
  output logic              txrdy
);

  tx_state_e             state_q;
  logic [FRAME_BITS-1:0] sr_q;
  logic [3:0]            bit_cnt_q;
  logic [BAUD_W-1:0]     baud_cnt_q;
  logic [7:0]            ldata_q;
  logic                  txrdy_q;

  logic d9;
  logic d10;
  logic btu;
  logic frame_end;

  uart_tx_engine_decode u_decode (
    .eight (eight),
    .pen   (pen),
    .ohel  (ohel),
    .d     (ldata_q),
    .d9    (d9),
    .d10   (d10)
  );

  assign btu       = (baud_cnt_q == k - 1'b1);
  assign frame_end = btu && (bit_cnt_q == 4'(FRAME_BITS - 1));

  // NOTE: every register, the shift register included, sits on the async
  // reset so tx and txrdy return to idle the moment reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= TX_IDLE;
      sr_q       <= IDLE_SR;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      ldata_q    <= '0;
      txrdy_q    <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (load && txrdy_q) begin
            ldata_q <= data;
            txrdy_q <= 1'b0;
            state_q <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          sr_q       <= {STOP_BIT, d10, d9, ldata_q[6:0], START_BIT};
          bit_cnt_q  <= '0;
          baud_cnt_q <= '0;
          state_q    <= TX_SHIFT;
        end
        TX_SHIFT: begin
          if (btu) begin
            baud_cnt_q <= '0;
            sr_q       <= {STOP_BIT, sr_q[FRAME_BITS-1:1]};
            if (frame_end) begin
              bit_cnt_q <= '0;
              txrdy_q   <= 1'b1;
              state_q   <= TX_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  // tx comes straight from a flop; the shift register idles at all ones.
  assign tx    = sr_q[0];
  assign txrdy = txrdy_q;

endmodule : uart_tx_engine
